// File: rtl/result_checker_pkg.sv
// Shared types and widths for the result checker.
package result_checker_pkg;

    // FSM encoding: IDLE=0, SETTLE=1, CHECK=2, REPORT=3.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    // Width of the mismatch counter (holds up to 16 without wrapping).
    localparam int CNT_W = 5;
    // Width of the channel index / first_fail.
    localparam int IDX_W = 4;
    // Width of the settle down-counter (SETTLE is 0..255).
    localparam int SETTLE_W = 8;

endpackage

// File: rtl/result_checker_compare.sv
// Four-state exact compare of one channel slice.
module chk_compare #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);

    // Case equality: X/Z bits must match exactly to count as equal.
    always_comb begin
        eq = (a === b);
    end

endmodule

// File: rtl/result_checker.sv
// Start-triggered checker: waits a settle interval, then compares one
// channel per cycle and reports pass, mismatch count and first failure.
//
// Handshake: start is a request sampled only in IDLE while no done pulse is
// showing; busy is high from the cycle after acceptance until the cycle done
// pulses; done is a single-cycle completion strobe. Nothing is queued.
module result_checker
    import result_checker_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NCH*WIDTH-1:0]   data,
    input  logic [NCH*WIDTH-1:0]   expected,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       mismatch_count,
    output logic [IDX_W-1:0]       first_fail,
    output state_t                 fsm_state
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
        (SETTLE > 0) ? SETTLE_W'(SETTLE - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    state_t              state, state_nxt;
    logic [SETTLE_W-1:0] cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic                busy_q, done_q, pass_q;
    logic [CNT_W-1:0]    mcount_q;
    logic [IDX_W-1:0]    ffail_q;
    logic                accept, last, eq;
    logic [WIDTH-1:0]    data_sel, exp_sel;

    // Select the channel currently under test.
    always_comb begin
        data_sel = data[32'(idx_q) * WIDTH +: WIDTH];
        exp_sel  = expected[32'(idx_q) * WIDTH +: WIDTH];
    end

    chk_compare #(.WIDTH(WIDTH)) u_cmp (
        .a  (data_sel),
        .b  (exp_sel),
        .eq (eq)
    );

    // Next-state logic; a start during the done cycle is not accepted.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = (idx_q == LAST_IDX);
        case (state)
            ST_IDLE: begin
                if (start && !done_q) begin
                    accept    = 1'b1;
                    state_nxt = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
                end
            end
            ST_SETTLE: if (cnt_q == '0) state_nxt = ST_CHECK;
            ST_CHECK:  if (last) state_nxt = ST_REPORT;
            ST_REPORT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Counters, index and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            mcount_q <= '0;
            ffail_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        busy_q   <= 1'b1;
                        pass_q   <= 1'b0;
                        mcount_q <= '0;
                        ffail_q  <= '0;
                        cnt_q    <= SETTLE_LOAD;
                        idx_q    <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    else             idx_q <= '0;
                end
                ST_CHECK: begin
                    if (!eq) begin
                        mcount_q <= mcount_q + 1'b1;
                        if (mcount_q == '0) ffail_q <= idx_q;
                    end
                    if (!last) idx_q <= idx_q + 1'b1;
                end
                ST_REPORT: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    pass_q <= (mcount_q == '0);
                    idx_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Drive outputs from registers.
    always_comb begin
        busy           = busy_q;
        done           = done_q;
        pass           = pass_q;
        mismatch_count = mcount_q;
        first_fail     = ffail_q;
        fsm_state      = state;
    end

endmodule

// File: tb/tb_result_checker.sv
// Self-checking bench for result_checker: one instance with SETTLE=1 and
// one with SETTLE=0, sharing data/expected, each with its own start.
module tb_result_checker;
    import result_checker_pkg::*;

    localparam int NCH   = 3;
    localparam int WIDTH = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start0 = 1'b0, start1 = 1'b0;
    logic [NCH*WIDTH-1:0] data = '0, expected = '0;
    logic                 busy0, done0, pass0, busy1, done1, pass1;
    logic [CNT_W-1:0]     mc0, mc1;
    logic [IDX_W-1:0]     ff0, ff1;
    state_t               st0, st1;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [WIDTH-1:0] ch_data [NCH];
    logic [WIDTH-1:0] ch_exp  [NCH];
    int               m_cnt, m_ff;
    logic             m_pass;

    // Output view of the selected instance.
    int               sel = 1;
    logic             busy_s, done_s, pass_s;
    logic [CNT_W-1:0] mc_s;
    logic [IDX_W-1:0] ff_s;

    always #5 clk = ~clk;

    result_checker #(.NCH(NCH), .WIDTH(WIDTH), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .data(data), .expected(expected),
        .busy(busy0), .done(done0), .pass(pass0), .mismatch_count(mc0),
        .first_fail(ff0), .fsm_state(st0)
    );

    result_checker #(.NCH(NCH), .WIDTH(WIDTH), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data(data), .expected(expected),
        .busy(busy1), .done(done1), .pass(pass1), .mismatch_count(mc1),
        .first_fail(ff1), .fsm_state(st1)
    );

    always_comb begin
        busy_s = (sel == 0) ? busy0 : busy1;
        done_s = (sel == 0) ? done0 : done1;
        pass_s = (sel == 0) ? pass0 : pass1;
        mc_s   = (sel == 0) ? mc0   : mc1;
        ff_s   = (sel == 0) ? ff0   : ff1;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Pack channels onto the buses and compute the expected result.
    task automatic load_and_model();
        int fails[$];
        for (int i = 0; i < NCH; i++) begin
            data[i*WIDTH +: WIDTH]     = ch_data[i];
            expected[i*WIDTH +: WIDTH] = ch_exp[i];
            if (ch_data[i] !== ch_exp[i]) fails.push_back(i);
        end
        m_cnt  = fails.size();
        m_ff   = (fails.size() > 0) ? fails[0] : 0;
        m_pass = (fails.size() == 0);
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 0) start0 = v;
        else        start1 = v;
    endtask

    // One full run on instance s: latency, busy/done timing and results.
    task automatic run_check(input int s, input string name);
        int lat;
        int exp_lat;
        sel     = s;
        exp_lat = ((s == 0) ? 0 : 1) + NCH + 1;
        load_and_model();
        @(negedge clk); set_start(s, 1'b1);
        @(negedge clk); set_start(s, 1'b0);
        checks++;
        if (busy_s !== 1'b1 || pass_s !== 1'b0) begin
            errors++;
            $display("FAIL %s start: busy=%b pass=%b want busy=1 pass=0", name, busy_s, pass_s);
        end
        lat = 0;
        while (done_s !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (busy_s !== 1'b0 || pass_s !== m_pass || mc_s !== CNT_W'(m_cnt) || ff_s !== IDX_W'(m_ff)) begin
            errors++;
            $display("FAIL %s result: busy=%b pass=%b count=%0d first=%0d want busy=0 pass=%b count=%0d first=%0d",
                     name, busy_s, pass_s, mc_s, ff_s, m_pass, m_cnt, m_ff);
        end
        @(negedge clk);
        checks++;
        if (done_s !== 1'b0 || pass_s !== m_pass || mc_s !== CNT_W'(m_cnt) || ff_s !== IDX_W'(m_ff)) begin
            errors++;
            $display("FAIL %s hold: done=%b pass=%b count=%0d first=%0d want done=0 pass=%b count=%0d first=%0d",
                     name, done_s, pass_s, mc_s, ff_s, m_pass, m_cnt, m_ff);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0 || mc1 !== '0 || ff1 !== '0 || st1 !== ST_IDLE) begin
            errors++;
            $display("FAIL reset1: busy=%b done=%b pass=%b count=%0d first=%0d state=%0d want all 0",
                     busy1, done1, pass1, mc1, ff1, st1);
        end
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0 || mc0 !== '0 || ff0 !== '0 || st0 !== ST_IDLE) begin
            errors++;
            $display("FAIL reset0: busy=%b done=%b pass=%b count=%0d first=%0d state=%0d want all 0",
                     busy0, done0, pass0, mc0, ff0, st0);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_match();
        ch_data[0] = 77; ch_data[1] = 66; ch_data[2] = 42;
        ch_exp[0]  = 77; ch_exp[1]  = 66; ch_exp[2]  = 42;
        run_check(1, "match");
    endtask

    task automatic test_mismatch();
        ch_data[0] = 77; ch_data[1] = 65; ch_data[2] = 0;
        ch_exp[0]  = 77; ch_exp[1]  = 66; ch_exp[2]  = 42;
        run_check(1, "mismatch");
    endtask

    task automatic test_x();
        ch_data[0] = 'x; ch_data[1] = 66; ch_data[2] = 42;
        ch_exp[0]  = 42; ch_exp[1]  = 66; ch_exp[2]  = 42;
        run_check(1, "x_vs_42");
        ch_exp[0]  = 'x;
        run_check(1, "x_vs_x");
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NCH; i++) begin
                ch_exp[i]  = $urandom;
                ch_data[i] = ($urandom_range(0, 2) == 0)
                           ? (ch_exp[i] ^ (32'h1 << $urandom_range(0, 31)))
                           : ch_exp[i];
            end
            run_check(int'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_settle0_restart();
        int n_done;
        int first_k;
        sel = 0;
        for (int i = 0; i < NCH; i++) begin
            ch_exp[i]  = $urandom;
            ch_data[i] = ch_exp[i];
        end
        load_and_model();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        n_done  = 0;
        first_k = -1;
        for (int k = 0; k < 12; k++) begin
            if (done0 === 1'b1) begin
                n_done++;
                if (first_k < 0) first_k = k;
            end
            start0 = (k == 1 || k == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start0 = 1'b0;
        checks++;
        if (n_done != 1 || first_k != 4) begin
            errors++;
            $display("FAIL settle0_restart: dones=%0d first_at=%0d want dones=1 first_at=4", n_done, first_k);
        end
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL settle0_ignored_start: busy=%b want 0", busy0);
        end
        run_check(0, "second_run");
    endtask

    task automatic test_reset_abort();
        int n_done;
        sel = 1;
        ch_data[0] = 5; ch_data[1] = 66; ch_data[2] = 42;
        ch_exp[0]  = 6; ch_exp[1]  = 66; ch_exp[2]  = 42;
        load_and_model();
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (st1 !== ST_CHECK || mc1 !== CNT_W'(1)) begin
            errors++;
            $display("FAIL abort_precheck: state=%0d count=%0d want state=2 count=1", st1, mc1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0 || mc1 !== '0 || ff1 !== '0 || st1 !== ST_IDLE) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b done=%b pass=%b count=%0d first=%0d state=%0d want all 0",
                     busy1, done1, pass1, mc1, ff1, st1);
        end
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            if (done1 === 1'b1) n_done++;
            @(negedge clk);
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL abort_no_done: dones=%0d want 0", n_done);
        end
        ch_data[0] = 6;
        run_check(1, "after_abort");
    endtask

    task automatic test_rst_start();
        @(negedge clk);
        rst = 1'b1; start1 = 1'b1;
        @(negedge clk);
        checks++;
        if (st1 !== ST_IDLE || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_start: state=%0d busy=%b want state=0 busy=0", st1, busy1);
        end
        rst = 1'b0; start1 = 1'b0;
        @(negedge clk);
        checks++;
        if (st1 !== ST_IDLE || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_after: state=%0d busy=%b want state=0 busy=0", st1, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_x();
        test_random();
        test_settle0_restart();
        test_reset_abort();
        test_rst_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
